adc_frame_rx: RTL and testbench



---
 rtl/adc_frame_rx.sv | 132 +++++++++++++
 tb/tb_adc_frame_rx.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_rx.sv
// rtl/adc_frame_rx.sv - eight-channel serial ADC frame receiver with word-sync strobe
// Frame position fc drives a two-process FSM; every output is registered from the next-cycle decode.
module adc_frame_rx #(
    parameter int FRAME_CYCLES = 50,
    parameter int CNV_CYCLES   = 4,
    parameter int WAIT_CYCLES  = 5,
    parameter int DATA_BITS    = 18,
    parameter int SYNC_CYCLES  = 5
) (
    input  logic                     ff_clk,
    input  logic                     pio_reset,
    input  logic                     acq_on,
    input  logic                     test_mode,
    input  logic [7:0]               adc_sdo,
    output logic                     adc_cnv,
    output logic                     adc_sclk,
    output logic [8*DATA_BITS-1:0]   data_out,
    output logic                     data_valid,
    output logic                     word_sync_n,
    output logic [15:0]              frame_count
);

    localparam int FCW = $clog2(FRAME_CYCLES + 1);
    localparam logic [FCW-1:0] LAST_FC     = FCW'(FRAME_CYCLES - 1);
    localparam logic [FCW-1:0] WAIT_START  = FCW'(CNV_CYCLES);
    localparam logic [FCW-1:0] SHIFT_START = FCW'(CNV_CYCLES + WAIT_CYCLES);
    localparam logic [FCW-1:0] LATCH_AT    = FCW'(CNV_CYCLES + WAIT_CYCLES + 2 * DATA_BITS);
    localparam logic [FCW-1:0] SYNC_END    = FCW'(CNV_CYCLES + WAIT_CYCLES + 2 * DATA_BITS + SYNC_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        CNV,
        WAIT,
        SHIFT,
        LATCH,
        HOLD
    } state_t;

    state_t               state, state_next;
    logic [FCW-1:0]       fc, fc_next;
    logic                 cnv_next, sclk_next, sync_n_next, valid_next;
    logic                 shift_en, latch;
    logic                 pair_second;
    logic [DATA_BITS-1:0] shreg [8];

    always_comb begin
        state_next  = IDLE;
        fc_next     = '0;
        cnv_next    = 1'b0;
        sclk_next   = 1'b0;
        sync_n_next = 1'b1;
        valid_next  = 1'b0;
        shift_en    = 1'b0;
        latch       = 1'b0;

        if (acq_on) begin
            // A frame always restarts at fc=0 after IDLE; aborted frames never resume.
            if (state == IDLE || fc == LAST_FC)
                fc_next = '0;
            else
                fc_next = fc + 1'b1;

            if (fc_next < WAIT_START)
                state_next = CNV;
            else if (fc_next < SHIFT_START)
                state_next = WAIT;
            else if (fc_next < LATCH_AT)
                state_next = SHIFT;
            else if (fc_next == LATCH_AT)
                state_next = LATCH;
            else
                state_next = HOLD;
        end

        pair_second = fc_next[0] ^ SHIFT_START[0];

        case (state_next)
            CNV:   cnv_next = 1'b1;
            SHIFT: begin
                sclk_next = ~pair_second;
                shift_en  = pair_second;
            end
            LATCH: begin
                valid_next = 1'b1;
                latch      = 1'b1;
            end
            default: ;
        endcase

        if (state_next != IDLE && fc_next >= LATCH_AT && fc_next < SYNC_END)
            sync_n_next = 1'b0;
    end

    always_ff @(posedge ff_clk or posedge pio_reset) begin
        if (pio_reset) begin
            state       <= IDLE;
            fc          <= '0;
            adc_cnv     <= 1'b0;
            adc_sclk    <= 1'b0;
            word_sync_n <= 1'b1;
            data_valid  <= 1'b0;
            data_out    <= '0;
            frame_count <= '0;
            for (int k = 0; k < 8; k++)
                shreg[k] <= '0;
        end else begin
            state       <= state_next;
            fc          <= fc_next;
            adc_cnv     <= cnv_next;
            adc_sclk    <= sclk_next;
            word_sync_n <= sync_n_next;
            data_valid  <= valid_next;

            for (int k = 0; k < 8; k++) begin
                if (state_next == IDLE)
                    shreg[k] <= '0;
                else if (shift_en)
                    shreg[k] <= {shreg[k][DATA_BITS-2:0], adc_sdo[k]};
            end

            // Test pattern uses the count before this frame's increment.
            if (latch) begin
                frame_count <= frame_count + 16'd1;
                for (int k = 0; k < 8; k++)
                    data_out[k*DATA_BITS +: DATA_BITS] <= test_mode
                        ? {3'(k), frame_count[DATA_BITS-4:0]}
                        : shreg[k];
            end
        end
    end

endmodule

// File: tb/tb_adc_frame_rx.sv
// tb/tb_adc_frame_rx.sv - self-checking bench for adc_frame_rx
// Serial ADC model plus a frame scoreboard checked whenever data_valid pulses.
module tb_adc_frame_rx;

    logic         ff_clk = 1'b0;
    logic         pio_reset;
    logic         acq_on;
    logic         test_mode;
    logic [7:0]   adc_sdo;
    logic         adc_cnv;
    logic         adc_sclk;
    logic [143:0] data_out;
    logic         data_valid;
    logic         word_sync_n;
    logic [15:0]  frame_count;

    adc_frame_rx dut (
        .ff_clk      (ff_clk),
        .pio_reset   (pio_reset),
        .acq_on      (acq_on),
        .test_mode   (test_mode),
        .adc_sdo     (adc_sdo),
        .adc_cnv     (adc_cnv),
        .adc_sclk    (adc_sclk),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .word_sync_n (word_sync_n),
        .frame_count (frame_count)
    );

    always #5 ff_clk = ~ff_clk;

    typedef struct {
        logic [143:0] data;
        logic [15:0]  cnt;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [17:0] adc_words [8];
    logic [17:0] sine_tab [4] = '{18'h00000, 18'h16A09, 18'h1FFFF, 18'h16A09};
    int          bit_idx = 17;
    logic        prev_sclk = 1'b0;

    // ADC model: reloads MSB on cnv, advances one bit after each sclk fall.
    always @(negedge ff_clk) begin
        if (adc_cnv === 1'b1)
            bit_idx = 17;
        else if (prev_sclk && adc_sclk === 1'b0 && bit_idx > 0)
            bit_idx = bit_idx - 1;
        prev_sclk = (adc_sclk === 1'b1);
        for (int i = 0; i < 8; i++)
            adc_sdo[i] = adc_words[i][bit_idx];
    end

    always @(negedge ff_clk) begin
        if (data_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: data_valid=1 with no frame expected, frame_count=%0d", frame_count);
            end else begin
                mon_e = exp_q.pop_front();
                if (data_out !== mon_e.data || frame_count !== mon_e.cnt) begin
                    errors++;
                    $display("FAIL frame_word: data_out=%h frame_count=%h expected data_out=%h frame_count=%h",
                             data_out, frame_count, mon_e.data, mon_e.cnt);
                end
            end
        end
    end

    function automatic logic [143:0] pack_words();
        logic [143:0] r;
        for (int k = 0; k < 8; k++)
            r[k*18 +: 18] = adc_words[k];
        return r;
    endfunction

    function automatic logic [143:0] pattern(input logic [15:0] c);
        logic [143:0] r;
        for (int k = 0; k < 8; k++)
            r[k*18 +: 18] = {3'(k), c[14:0]};
        return r;
    endfunction

    function automatic exp_t mk(input logic [143:0] d, input logic [15:0] c);
        exp_t e;
        e.data = d;
        e.cnt  = c;
        return e;
    endfunction

    task automatic do_reset();
        pio_reset = 1'b1;
        acq_on    = 1'b0;
        test_mode = 1'b0;
        repeat (2) @(negedge ff_clk);
        pio_reset = 1'b0;
        @(negedge ff_clk);
    endtask

    task automatic test_reset();
        @(negedge ff_clk);
        checks++;
        if ({adc_cnv, adc_sclk, word_sync_n, data_valid} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_strobes: cnv/sclk/sync_n/valid=%b expected 0010",
                     {adc_cnv, adc_sclk, word_sync_n, data_valid});
        end
        checks++;
        if (data_out !== 144'd0) begin
            errors++;
            $display("FAIL reset_data: data_out=%h expected 0", data_out);
        end
        checks++;
        if (frame_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: frame_count=%0d expected 0", frame_count);
        end
        pio_reset = 1'b0;
        @(negedge ff_clk);
    endtask

    task automatic test_frame_timing();
        int  f;
        logic [3:0] e;
        for (int i = 0; i < 8; i++)
            adc_words[i] = 18'h2A5A5 ^ 18'(i);
        exp_q.push_back(mk(pack_words(), 16'd1));
        exp_q.push_back(mk(pack_words(), 16'd2));
        acq_on = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge ff_clk);
            f = c % 50;
            e = {f < 4, (f >= 9 && f < 45 && (f % 2) == 1), !(f >= 45), f == 45};
            checks++;
            if ({adc_cnv, adc_sclk, word_sync_n, data_valid} !== e) begin
                errors++;
                $display("FAIL timing cycle %0d: cnv/sclk/sync_n/valid=%b expected %b",
                         c, {adc_cnv, adc_sclk, word_sync_n, data_valid}, e);
            end
            if (c == 45) begin
                checks++;
                if (data_out[17:0] !== 18'h2A5A5 || data_out[143:126] !== 18'h2A5A2) begin
                    errors++;
                    $display("FAIL ch1_ch8: ch1=%h ch8=%h expected 2a5a5 2a5a2",
                             data_out[17:0], data_out[143:126]);
                end
            end
        end
        acq_on = 1'b0;
        @(negedge ff_clk);
        checks++;
        if (frame_count !== 16'd2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL timing_end: frame_count=%0d pending=%0d expected 2 and 0",
                     frame_count, exp_q.size());
        end
    endtask

    task automatic test_test_mode();
        int n;
        do_reset();
        test_mode = 1'b1;
        for (int i = 0; i < 8; i++)
            adc_words[i] = 18'($urandom);
        for (int k = 0; k < 3; k++)
            exp_q.push_back(mk(pattern(16'(k)), 16'(k + 1)));
        n = 0;
        acq_on = 1'b1;
        for (int c = 0; c < 150; c++) begin
            @(negedge ff_clk);
            if (data_valid === 1'b1) begin
                checks++;
                if (data_out[53:36] !== 18'h10000 + 18'(n)) begin
                    errors++;
                    $display("FAIL ch3_pattern frame %0d: ch3=%h expected %h",
                             n, data_out[53:36], 18'h10000 + 18'(n));
                end
                n++;
            end
        end
        acq_on = 1'b0;
        @(negedge ff_clk);
        checks++;
        if (frame_count !== 16'd3 || exp_q.size() != 0 || n != 3) begin
            errors++;
            $display("FAIL test_mode_end: frame_count=%0d pending=%0d frames=%0d expected 3 0 3",
                     frame_count, exp_q.size(), n);
        end
        test_mode = 1'b0;
    endtask

    task automatic test_abort();
        logic [143:0] f1;
        int bad;
        do_reset();
        adc_words[0] = sine_tab[0];
        adc_words[1] = sine_tab[0];
        for (int i = 2; i < 8; i++)
            adc_words[i] = 18'($urandom);
        f1 = pack_words();
        exp_q.push_back(mk(f1, 16'd1));
        acq_on = 1'b1;
        repeat (71) @(negedge ff_clk);
        acq_on = 1'b0;
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge ff_clk);
            if ({adc_cnv, adc_sclk, word_sync_n, data_valid} !== 4'b0010)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_idle: %0d cycles with strobes active, expected 0", bad);
        end
        checks++;
        if (data_out !== f1 || frame_count !== 16'd1) begin
            errors++;
            $display("FAIL abort_hold: data_out=%h frame_count=%0d expected %h 1", data_out, frame_count, f1);
        end
        adc_words[0] = sine_tab[1];
        adc_words[1] = sine_tab[1];
        exp_q.push_back(mk(pack_words(), 16'd2));
        acq_on = 1'b1;
        @(negedge ff_clk);
        checks++;
        if (adc_cnv !== 1'b1) begin
            errors++;
            $display("FAIL restart_cnv: adc_cnv=%b expected 1", adc_cnv);
        end
        repeat (49) @(negedge ff_clk);
        acq_on = 1'b0;
        @(negedge ff_clk);
        checks++;
        if (frame_count !== 16'd2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL restart_frame: frame_count=%0d pending=%0d expected 2 0", frame_count, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int i = 0; i < 8; i++)
            adc_words[i] = 18'($urandom);
        exp_q.push_back(mk(pack_words(), 16'd1));
        acq_on = 1'b1;
        repeat (82) @(negedge ff_clk);
        #2;
        pio_reset = 1'b1;
        #1;
        checks++;
        if ({adc_cnv, adc_sclk, word_sync_n, data_valid} !== 4'b0010 || data_out !== 144'd0 || frame_count !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: cnv/sclk/sync_n/valid=%b data_out=%h frame_count=%0d expected 0010 0 0",
                     {adc_cnv, adc_sclk, word_sync_n, data_valid}, data_out, frame_count);
        end
        exp_q.push_back(mk(pack_words(), 16'd1));
        @(negedge ff_clk);
        pio_reset = 1'b0;
        @(negedge ff_clk);
        checks++;
        if (adc_cnv !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_cnv: adc_cnv=%b expected 1", adc_cnv);
        end
        repeat (49) @(negedge ff_clk);
        acq_on = 1'b0;
        @(negedge ff_clk);
        checks++;
        if (frame_count !== 16'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_frame: frame_count=%0d pending=%0d expected 1 0", frame_count, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        logic [14:0] want [3];
        int n;
        want[0] = 15'h7FFE;
        want[1] = 15'h7FFF;
        want[2] = 15'h0000;
        do_reset();
        test_mode = 1'b1;
        #2;
        force dut.frame_count = 16'hFFFE;
        #1;
        release dut.frame_count;
        exp_q.push_back(mk(pattern(16'hFFFE), 16'hFFFF));
        exp_q.push_back(mk(pattern(16'hFFFF), 16'h0000));
        exp_q.push_back(mk(pattern(16'h0000), 16'h0001));
        @(negedge ff_clk);
        n = 0;
        acq_on = 1'b1;
        for (int c = 0; c < 150; c++) begin
            @(negedge ff_clk);
            if (data_valid === 1'b1 && n < 3) begin
                checks++;
                if (data_out[14:0] !== want[n]) begin
                    errors++;
                    $display("FAIL wrap_pattern frame %0d: ch1 field=%h expected %h", n, data_out[14:0], want[n]);
                end
                n++;
            end
        end
        acq_on = 1'b0;
        @(negedge ff_clk);
        checks++;
        if (frame_count !== 16'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_end: frame_count=%0d pending=%0d expected 1 0", frame_count, exp_q.size());
        end
        test_mode = 1'b0;
    endtask

    initial begin
        pio_reset = 1'b1;
        acq_on    = 1'b0;
        test_mode = 1'b0;
        for (int i = 0; i < 8; i++)
            adc_words[i] = '0;
        test_reset();
        test_frame_timing();
        test_test_mode();
        test_abort();
        test_reset_mid_frame();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
